// File: rtl/video_overlay_mixer.sv
// Pixel compositor: camera + sprite + decimal score + blinking "LOSE" banner, RGB565 in, 4:4:4 out.
// Latency: 2 cycles x/y -> RGB. No backpressure; one pixel per clock, score conversion runs alongside.
module video_overlay_mixer #(
    parameter int          SCORE_W      = 8,
    parameter int          NUM_DIGITS   = 3,
    parameter int          TEXT_X       = 500,
    parameter int          TEXT_Y       = 40,
    parameter int          SCALE        = 2,
    parameter int          BANNER_X     = 280,
    parameter int          BANNER_Y     = 200,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [15:0] TEXT_COLOR   = 16'hFFFF,
    parameter logic [15:0] BANNER_COLOR = 16'hF001
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         x_pixel,
    input  logic [9:0]         y_pixel,
    input  logic               frame_start,
    input  logic [15:0]        camera_pixel,
    input  logic [15:0]        rom_pixel,
    input  logic [SCORE_W-1:0] score,
    input  logic [9:0]         ball_x,
    input  logic [9:0]         ball_y,
    input  logic [1:0]         ball_size,
    input  logic               is_idle,
    input  logic               game_over,
    output logic [5:0]         x_offset,
    output logic [5:0]         y_offset,
    output logic [3:0]         red_port,
    output logic [3:0]         green_port,
    output logic [3:0]         blue_port,
    output logic               is_hit_area,
    output logic               bcd_busy
);

    localparam int SC_SH    = $clog2(SCALE);
    localparam int GL_SH    = SC_SH + 3;
    localparam int GLYPH    = 8 * SCALE;
    localparam int BCD_NEED = (SCORE_W + 2) / 3;
    localparam int BCD_N    = (BCD_NEED > NUM_DIGITS) ? BCD_NEED : NUM_DIGITS;
    localparam int CNT_W    = $clog2(SCORE_W + 1);
    localparam int BLK_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [63:0] SAT_MAX = 64'(10 ** NUM_DIGITS - 1);

    localparam logic [3:0] CH_L     = 4'd10;
    localparam logic [3:0] CH_O     = 4'd11;
    localparam logic [3:0] CH_S     = 4'd12;
    localparam logic [3:0] CH_E     = 4'd13;
    localparam logic [3:0] CH_BLANK = 4'd15;

    typedef enum logic [1:0] {BCD_IDLE, BCD_SHIFT, BCD_DONE} bcd_state_t;
    typedef enum logic [1:0] {BAN_OFF, BAN_ON, BAN_DARK} ban_state_t;

    // 8x8 glyphs, top row in the most significant byte, leftmost pixel in bit 7.
    function automatic logic [7:0] font_row(input logic [3:0] ch, input logic [2:0] row);
        logic [63:0] g;
        case (ch)
            4'd0:    g = 64'h3C666E7666663C00;
            4'd1:    g = 64'h1838181818187E00;
            4'd2:    g = 64'h3C66060C30607E00;
            4'd3:    g = 64'h3C66061C06663C00;
            4'd4:    g = 64'h0C1C3C6C7E0C0C00;
            4'd5:    g = 64'h7E607C0606663C00;
            4'd6:    g = 64'h3C607C6666663C00;
            4'd7:    g = 64'h7E060C1830303000;
            4'd8:    g = 64'h3C66663C66663C00;
            4'd9:    g = 64'h3C66663E060C3800;
            CH_L:    g = 64'h6060606060607E00;
            CH_O:    g = 64'h3C66666666663C00;
            CH_S:    g = 64'h3C60603C06063C00;
            CH_E:    g = 64'h7E60607C60607E00;
            default: g = 64'h0;
        endcase
        return g[{3'd7 - row, 3'b000} +: 8];
    endfunction

    function automatic logic [4*BCD_N-1:0] add3(input logic [4*BCD_N-1:0] b);
        logic [4*BCD_N-1:0] r;
        r = b;
        for (int i = 0; i < BCD_N; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // ---------------- S1: region decode ----------------
    logic [11:0] xe, ye, sdx, sdy, bdx, bdy;
    logic        s_box, b_box, spr_box;
    logic [10:0] spr_sz;

    assign xe  = {2'b00, x_pixel};
    assign ye  = {2'b00, y_pixel};
    assign sdx = xe - 12'(TEXT_X);
    assign sdy = ye - 12'(TEXT_Y);
    assign bdx = xe - 12'(BANNER_X);
    assign bdy = ye - 12'(BANNER_Y);

    assign x_offset = 6'(x_pixel - ball_x);
    assign y_offset = 6'(y_pixel - ball_y);

    always_comb begin
        case (ball_size)
            2'd0:    spr_sz = 11'd20;
            2'd1:    spr_sz = 11'd40;
            default: spr_sz = 11'd64;
        endcase
    end

    assign s_box = (xe >= 12'(TEXT_X)) && (xe < 12'(TEXT_X + NUM_DIGITS * GLYPH))
                && (ye >= 12'(TEXT_Y)) && (ye < 12'(TEXT_Y + GLYPH));
    assign b_box = (xe >= 12'(BANNER_X)) && (xe < 12'(BANNER_X + 4 * GLYPH))
                && (ye >= 12'(BANNER_Y)) && (ye < 12'(BANNER_Y + GLYPH));
    // 11-bit compare so a sprite near the right/bottom edge never wraps to column/row 0.
    assign spr_box = ({1'b0, x_pixel} >= {1'b0, ball_x}) && ({1'b0, x_pixel} < {1'b0, ball_x} + spr_sz)
                  && ({1'b0, y_pixel} >= {1'b0, ball_y}) && ({1'b0, y_pixel} < {1'b0, ball_y} + spr_sz);

    logic       s1_sbox, s1_bbox, s1_sprite;
    logic [3:0] s1_sidx;
    logic [1:0] s1_bidx;
    logic [2:0] s1_scol, s1_srow, s1_bcol, s1_brow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_sbox   <= 1'b0;
            s1_bbox   <= 1'b0;
            s1_sprite <= 1'b0;
            s1_sidx   <= '0;
            s1_bidx   <= '0;
            s1_scol   <= '0;
            s1_srow   <= '0;
            s1_bcol   <= '0;
            s1_brow   <= '0;
        end else begin
            s1_sbox   <= s_box;
            s1_bbox   <= b_box;
            s1_sprite <= spr_box;
            s1_sidx   <= 4'(sdx >> GL_SH);
            s1_scol   <= 3'(sdx >> SC_SH);
            s1_srow   <= 3'(sdy >> SC_SH);
            s1_bidx   <= 2'(bdx >> GL_SH);
            s1_bcol   <= 3'(bdx >> SC_SH);
            s1_brow   <= 3'(bdy >> SC_SH);
        end
    end

    // ---------------- S2: font lookup and priority mux ----------------
    logic [3:0] disp_dig [NUM_DIGITS];
    logic [3:0] score_char [NUM_DIGITS];
    logic [3:0] s_ch, b_ch;
    logic [7:0] srow_bits, brow_bits;
    logic       lead, ban_lit, spr_lit, txt_lit;
    logic [15:0] pix;
    ban_state_t ban_state, ban_next;

    // Glyph 0 is the most significant digit; zeros are blanked until the first non-zero or the ones digit.
    always_comb begin
        lead = 1'b1;
        for (int g = 0; g < NUM_DIGITS; g++) begin
            score_char[g] = disp_dig[NUM_DIGITS-1-g];
            if (lead && (disp_dig[NUM_DIGITS-1-g] == 4'd0) && (g != NUM_DIGITS - 1))
                score_char[g] = CH_BLANK;
            else
                lead = 1'b0;
        end
    end

    always_comb begin
        s_ch = CH_BLANK;
        for (int g = 0; g < NUM_DIGITS; g++) begin
            if (s1_sidx == 4'(g)) s_ch = score_char[g];
        end
        case (s1_bidx)
            2'd0:    b_ch = CH_L;
            2'd1:    b_ch = CH_O;
            2'd2:    b_ch = CH_S;
            default: b_ch = CH_E;
        endcase
    end

    assign srow_bits = font_row(s_ch, s1_srow);
    assign brow_bits = font_row(b_ch, s1_brow);
    assign ban_lit   = s1_bbox && (ban_state == BAN_ON) && brow_bits[3'd7 - s1_bcol];
    assign spr_lit   = s1_sprite && (rom_pixel != 16'h0) && !is_idle;
    assign txt_lit   = s1_sbox && srow_bits[3'd7 - s1_scol];

    always_comb begin
        pix = camera_pixel;
        if (ban_lit)      pix = BANNER_COLOR;
        else if (spr_lit) pix = rom_pixel;
        else if (txt_lit) pix = TEXT_COLOR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            red_port    <= '0;
            green_port  <= '0;
            blue_port   <= '0;
            is_hit_area <= 1'b0;
        end else begin
            red_port    <= 4'(pix >> 12);
            green_port  <= 4'(pix >> 7);
            blue_port   <= 4'(pix >> 1);
            is_hit_area <= s1_sprite;
        end
    end

    // ---------------- Score conversion (double dabble) ----------------
    bcd_state_t           bcd_state, bcd_next;
    logic [4*BCD_N-1:0]   dd_bcd;
    logic [SCORE_W-1:0]   dd_bin, lat_score, last_conv;
    logic [CNT_W-1:0]     dd_cnt;
    logic                 sat;

    assign sat = 64'(lat_score) > SAT_MAX;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bcd_state <= BCD_IDLE;
        else          bcd_state <= bcd_next;
    end

    always_comb begin
        bcd_next = bcd_state;
        bcd_busy = 1'b0;
        case (bcd_state)
            BCD_IDLE:  if (frame_start && (score != last_conv)) bcd_next = BCD_SHIFT;
            BCD_SHIFT: begin
                bcd_busy = 1'b1;
                if (dd_cnt == CNT_W'(SCORE_W - 1)) bcd_next = BCD_DONE;
            end
            BCD_DONE:  bcd_next = BCD_IDLE;
            default:   bcd_next = BCD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dd_bcd    <= '0;
            dd_bin    <= '0;
            dd_cnt    <= '0;
            lat_score <= '0;
            last_conv <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) disp_dig[k] <= 4'd0;
        end else begin
            case (bcd_state)
                BCD_IDLE: if (bcd_next == BCD_SHIFT) begin
                    lat_score <= score;
                    dd_bin    <= score;
                    dd_bcd    <= '0;
                    dd_cnt    <= '0;
                end
                BCD_SHIFT: begin
                    {dd_bcd, dd_bin} <= {add3(dd_bcd), dd_bin} << 1;
                    dd_cnt           <= dd_cnt + 1'b1;
                end
                BCD_DONE: begin
                    last_conv <= lat_score;
                    for (int k = 0; k < NUM_DIGITS; k++)
                        disp_dig[k] <= sat ? 4'd9 : dd_bcd[4*k +: 4];
                end
                default: ;
            endcase
        end
    end

    // ---------------- Banner blink FSM (advances only on frame_start) ----------------
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_last;

    assign blink_last = (blink_cnt == BLK_W'(BLINK_FRAMES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ban_state <= BAN_OFF;
        else          ban_state <= ban_next;
    end

    always_comb begin
        ban_next = ban_state;
        if (frame_start) begin
            case (ban_state)
                BAN_OFF:  if (game_over) ban_next = BAN_ON;
                BAN_ON:   if (!game_over) ban_next = BAN_OFF; else if (blink_last) ban_next = BAN_DARK;
                BAN_DARK: if (!game_over) ban_next = BAN_OFF; else if (blink_last) ban_next = BAN_ON;
                default:  ban_next = BAN_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
        end else if (frame_start) begin
            if ((ban_state == BAN_OFF) || !game_over || blink_last) blink_cnt <= '0;
            else                                                     blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_video_overlay_mixer.sv
// Directed bench for video_overlay_mixer: pixel vector table plus score-conversion and banner sequences.
module tb_video_overlay_mixer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] x_pixel, y_pixel, ball_x, ball_y;
    logic       frame_start;
    logic [15:0] camera_pixel, rom_pixel;
    logic [7:0] score;
    logic [1:0] ball_size;
    logic       is_idle, game_over;
    logic [5:0] x_offset, y_offset;
    logic [3:0] red_port, green_port, blue_port;
    logic       is_hit_area, bcd_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_overlay_mixer #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .reset_n(reset_n), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .frame_start(frame_start), .camera_pixel(camera_pixel), .rom_pixel(rom_pixel),
        .score(score), .ball_x(ball_x), .ball_y(ball_y), .ball_size(ball_size),
        .is_idle(is_idle), .game_over(game_over), .x_offset(x_offset), .y_offset(y_offset),
        .red_port(red_port), .green_port(green_port), .blue_port(blue_port),
        .is_hit_area(is_hit_area), .bcd_busy(bcd_busy)
    );

    typedef struct {
        logic [9:0]  x, y, bx, by;
        logic [1:0]  sz;
        logic        idle;
        logic [15:0] cam, rom;
        logic [11:0] exp_rgb;
        logic        exp_hit;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_pix(input string nm, input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] bx, input logic [9:0] by, input logic [1:0] sz,
                             input logic idle, input logic [15:0] cam, input logic [15:0] rom,
                             input logic [11:0] er, input logic eh, input bit off);
        @(negedge clk);
        x_pixel = x; y_pixel = y; ball_x = bx; ball_y = by; ball_size = sz;
        is_idle = idle; camera_pixel = cam; rom_pixel = rom;
        #1;
        if (off) begin
            chk({nm, "_xoff"}, 32'(x_offset), 32'(6'(x - bx)));
            chk({nm, "_yoff"}, 32'(y_offset), 32'(6'(y - by)));
        end
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_rgb"}, {20'h0, red_port, green_port, blue_port}, 32'(er));
        chk({nm, "_hit"}, 32'(is_hit_area), 32'(eh));
    endtask

    // Score pixel with sprite parked elsewhere and camera 5555 ({5,A,A}).
    task automatic text_pix(input string nm, input logic [9:0] x, input logic [9:0] y, input logic lit);
        check_pix(nm, x, y, 10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h1234, lit ? 12'hFFF : 12'h5AA, 1'b0, 1'b0);
    endtask

    task automatic pulse_fs();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bcd_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("busy_fall", 32'(bcd_busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic start_conv(output int n);
        pulse_fs();
        chk("busy_rise", 32'(bcd_busy), 32'd1);
        wait_idle(n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic lit;
        reset_n = 1'b1; x_pixel = '0; y_pixel = '0; ball_x = '0; ball_y = '0; ball_size = '0;
        frame_start = 1'b0; camera_pixel = 16'h5555; rom_pixel = '0; score = '0;
        is_idle = 1'b0; game_over = 1'b0;

        //            x       y       bx       by      sz    idle  cam       rom       rgb      hit
        tbl[0]  = '{10'd139, 10'd119, 10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h1234, 12'h14A, 1'b1};
        tbl[1]  = '{10'd140, 10'd119, 10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h1234, 12'h5AA, 1'b0};
        tbl[2]  = '{10'd100, 10'd80,  10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h1234, 12'h14A, 1'b1};
        tbl[3]  = '{10'd99,  10'd80,  10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h1234, 12'h5AA, 1'b0};
        tbl[4]  = '{10'd139, 10'd120, 10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h1234, 12'h5AA, 1'b0};
        tbl[5]  = '{10'd139, 10'd119, 10'd100, 10'd80, 2'd1, 1'b1, 16'h5555, 16'h1234, 12'h5AA, 1'b1};
        tbl[6]  = '{10'd139, 10'd119, 10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h0000, 12'h5AA, 1'b1};
        tbl[7]  = '{10'd119, 10'd99,  10'd100, 10'd80, 2'd0, 1'b0, 16'h5555, 16'h1234, 12'h14A, 1'b1};
        tbl[8]  = '{10'd120, 10'd99,  10'd100, 10'd80, 2'd0, 1'b0, 16'h5555, 16'h1234, 12'h5AA, 1'b0};
        tbl[9]  = '{10'd163, 10'd143, 10'd100, 10'd80, 2'd2, 1'b0, 16'h5555, 16'h1234, 12'h14A, 1'b1};
        tbl[10] = '{10'd164, 10'd143, 10'd100, 10'd80, 2'd3, 1'b0, 16'h5555, 16'h1234, 12'h5AA, 1'b0};
        tbl[11] = '{10'd1015, 10'd85, 10'd1010, 10'd80, 2'd2, 1'b0, 16'h5555, 16'h1234, 12'h14A, 1'b1};
        tbl[12] = '{10'd5,   10'd85,  10'd1010, 10'd80, 2'd2, 1'b0, 16'h5555, 16'h1234, 12'h5AA, 1'b0};
        tbl[13] = '{10'd536, 10'd40,  10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h1234, 12'hFFF, 1'b0};
        tbl[14] = '{10'd532, 10'd40,  10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h1234, 12'h5AA, 1'b0};
        tbl[15] = '{10'd520, 10'd40,  10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h1234, 12'h5AA, 1'b0};
        tbl[16] = '{10'd536, 10'd40,  10'd530, 10'd38, 2'd0, 1'b0, 16'h5555, 16'h1234, 12'h14A, 1'b1};
        tbl[17] = '{10'd536, 10'd40,  10'd530, 10'd38, 2'd0, 1'b0, 16'h5555, 16'h0000, 12'hFFF, 1'b1};
        tbl[18] = '{10'd536, 10'd56,  10'd100, 10'd80, 2'd1, 1'b0, 16'h5555, 16'h1234, 12'h5AA, 1'b0};
        tbl[19] = '{10'd548, 10'd40,  10'd100, 10'd80, 2'd1, 1'b0, 16'h0000, 16'h1234, 12'h000, 1'b0};

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_rgb", {20'h0, red_port, green_port, blue_port}, 32'h0);
        chk("rst_hit", 32'(is_hit_area), 32'd0);
        chk("rst_busy", 32'(bcd_busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_rgb_clk", {20'h0, red_port, green_port, blue_port}, 32'h0);
        reset_n = 1'b1;

        // Pixel table (score shows "  0", banner off)
        for (int i = 0; i < 20; i++)
            check_pix($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].bx, tbl[i].by, tbl[i].sz,
                      tbl[i].idle, tbl[i].cam, tbl[i].rom, tbl[i].exp_rgb, tbl[i].exp_hit, 1'b1);

        // Score 7: eight busy cycles, then blank,blank,"7"
        score = 8'd7;
        start_conv(n);
        chk("busy_cycles_7", 32'(n), 32'd8);
        text_pix("s7_spec_px", 10'd536, 10'd40, 1'b1);
        text_pix("s7_row0_col1", 10'd534, 10'd40, 1'b1);
        text_pix("s7_row1_col1", 10'd534, 10'd42, 1'b0);
        text_pix("s7_tens_blank", 10'd520, 10'd40, 1'b0);

        // Score 5, changed to 6 mid-conversion plus a frame_start while busy: both ignored
        score = 8'd5;
        pulse_fs();
        @(negedge clk);
        score = 8'd6;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_idle(n);
        text_pix("s5_row2_col1", 10'd534, 10'd44, 1'b1);
        text_pix("s5_row0_col1", 10'd534, 10'd40, 1'b1);
        repeat (20) @(negedge clk);
        chk("s5_hold_idle", 32'(bcd_busy), 32'd0);
        text_pix("s5_hold", 10'd534, 10'd40, 1'b1);
        start_conv(n);
        text_pix("s6_row0_col1", 10'd534, 10'd40, 1'b0);

        // Reset in the middle of converting 200
        score = 8'd200;
        pulse_fs();
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bcd_busy), 32'd0);
        chk("midrst_rgb", {20'h0, red_port, green_port, blue_port}, 32'h0);
        chk("midrst_hit", 32'(is_hit_area), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        text_pix("midrst_ones0", 10'd536, 10'd40, 1'b1);
        text_pix("midrst_tens_blank", 10'd520, 10'd40, 1'b0);
        start_conv(n);
        text_pix("s200_hundreds", 10'd504, 10'd40, 1'b1);
        text_pix("s200_tens_zero", 10'd520, 10'd40, 1'b1);
        text_pix("s200_ones_zero", 10'd536, 10'd40, 1'b1);

        // Banner blink with BLINK_FRAMES=2, sprite underneath the lit 'L' pixel
        game_over = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            pulse_fs();
            lit = (f == 1 || f == 2 || f == 5 || f == 6);
            check_pix($sformatf("ban_f%0d", f), 10'd282, 10'd200, 10'd270, 10'd190, 2'd1, 1'b0,
                      16'h5555, 16'h1234, lit ? 12'hF00 : 12'h14A, 1'b1, 1'b0);
        end
        check_pix("ban_unlit_px", 10'd280, 10'd200, 10'd270, 10'd190, 2'd1, 1'b0,
                  16'h5555, 16'h1234, 12'h14A, 1'b1, 1'b0);
        check_pix("ban_no_sprite", 10'd282, 10'd200, 10'd100, 10'd80, 2'd1, 1'b0,
                  16'h5555, 16'h1234, 12'hF00, 1'b0, 1'b0);
        game_over = 1'b0;
        check_pix("ban_hold_off", 10'd282, 10'd200, 10'd270, 10'd190, 2'd1, 1'b0,
                  16'h5555, 16'h1234, 12'hF00, 1'b1, 1'b0);
        pulse_fs();
        check_pix("ban_off", 10'd282, 10'd200, 10'd270, 10'd190, 2'd1, 1'b0,
                  16'h5555, 16'h1234, 12'h14A, 1'b1, 1'b0);

        // Re-entry starts a fresh on-phase
        game_over = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            pulse_fs();
            check_pix($sformatf("ban_re_f%0d", f), 10'd282, 10'd200, 10'd100, 10'd80, 2'd1, 1'b0,
                      16'h5555, 16'h1234, (f < 3) ? 12'hF00 : 12'h5AA, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
